// File: rtl/gpio_filt_irq_if.sv
// Register-access channel of gpio_filt_irq: one-cycle request, response one cycle later.
interface gpio_filt_irq_if;
  logic        req_i;
  logic        we_i;
  logic [5:0]  addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport slave  (input  req_i, we_i, addr_i, wdata_i, output rvalid_o, rdata_o, err_o);
  modport master (output req_i, we_i, addr_i, wdata_i, input  rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/gpio_filt_irq.sv
// GPIO block: per-pin synchroniser + glitch filter, edge/level interrupts,
// output/enable registers behind a small word-addressed register map.
module gpio_filt_irq_pin #(
  parameter int FilterCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_pin,
  input  logic i_fen,
  output logic o_filt
);
  localparam logic [15:0] CntMax = 16'(FilterCycles - 1);

  logic        r_s1, r_s2, r_s3, r_fen_d, r_filt;
  logic [15:0] r_cnt;
  logic        w_stable;

  // r_cnt counts earlier cycles r_s2 has held; the current cycle makes FilterCycles
  assign w_stable = (r_s2 == r_s3) && (r_cnt >= CntMax);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_fen_d <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_pin;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_fen_d <= i_fen;
      if (i_fen != r_fen_d)   r_cnt <= '0;
      else if (r_s2 != r_s3)  r_cnt <= 16'd1;
      else if (r_cnt < CntMax) r_cnt <= r_cnt + 16'd1;
      if (!i_fen || w_stable) r_filt <= r_s2;
    end
  end

  assign o_filt = r_filt;
endmodule

module gpio_filt_irq #(
  parameter int Width        = 32,
  parameter int FilterCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gpio_filt_irq_if.slave   bus,
  input  logic [Width-1:0] gpio_i,
  output logic [Width-1:0] gpio_o,
  output logic [Width-1:0] gpio_oe_o,
  output logic [Width-1:0] irq_o
);
  localparam logic [3:0] AIntrState = 4'h0, AIntrEn  = 4'h1, AIntrTest = 4'h2,
                         ADataIn    = 4'h3, ADataOut = 4'h4, AOutSet   = 4'h5,
                         AOutClr    = 4'h6, AOutTgl  = 4'h7, AOe       = 4'h8,
                         AEnRise    = 4'h9, AEnFall  = 4'hA, AEnHigh   = 4'hB,
                         AEnLow     = 4'hC, AFiltEn  = 4'hD;

  logic [Width-1:0] r_state, r_en, r_dout, r_oe, r_rise, r_fall, r_high, r_low, r_fen, r_prev;
  logic             r_rvalid, r_err;
  logic [31:0]      r_rdata;

  logic [Width-1:0] w_filt, w_evt, w_w1c, w_test, w_wd, w_rval;
  logic [3:0]       w_idx;
  logic             w_wr, w_map;
  logic             w_unused;

  assign w_idx    = bus.addr_i[5:2];
  assign w_wr     = bus.req_i & bus.we_i;
  assign w_wd     = bus.wdata_i[Width-1:0];
  assign w_unused = ^{bus.addr_i[1:0], bus.wdata_i};

  for (genvar g = 0; g < Width; g++) begin : g_pin
    gpio_filt_irq_pin #(.FilterCycles(FilterCycles)) u_pin (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_pin  (gpio_i[g]),
      .i_fen  (r_fen[g]),
      .o_filt (w_filt[g])
    );
  end

  assign w_evt  = (~r_prev & w_filt & r_rise) | (r_prev & ~w_filt & r_fall)
                | (w_filt & r_high) | (~w_filt & r_low);
  assign w_w1c  = (w_wr && w_idx == AIntrState) ? w_wd : '0;
  assign w_test = (w_wr && w_idx == AIntrTest)  ? w_wd : '0;

  always_comb begin
    w_rval = '0;
    w_map  = 1'b1;
    case (w_idx)
      AIntrState: w_rval = r_state;
      AIntrEn:    w_rval = r_en;
      ADataIn:    w_rval = w_filt;
      ADataOut:   w_rval = r_dout;
      AOe:        w_rval = r_oe;
      AEnRise:    w_rval = r_rise;
      AEnFall:    w_rval = r_fall;
      AEnHigh:    w_rval = r_high;
      AEnLow:     w_rval = r_low;
      AFiltEn:    w_rval = r_fen;
      AIntrTest, AOutSet, AOutClr, AOutTgl: w_rval = '0;
      default:    w_map  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= '0;
      r_en     <= '0;
      r_dout   <= '0;
      r_oe     <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_high   <= '0;
      r_low    <= '0;
      r_fen    <= '0;
      r_prev   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_prev   <= w_filt;
      // set terms are OR'd after the clear so an event wins over a same-cycle W1C
      r_state  <= (r_state & ~w_w1c) | w_evt | w_test;
      r_rvalid <= bus.req_i;
      r_err    <= bus.req_i & ~w_map;
      r_rdata  <= (bus.req_i && !bus.we_i && w_map) ? 32'(w_rval) : '0;
      if (w_wr) begin
        case (w_idx)
          AIntrEn:  r_en   <= w_wd;
          ADataOut: r_dout <= w_wd;
          AOutSet:  r_dout <= r_dout | w_wd;
          AOutClr:  r_dout <= r_dout & ~w_wd;
          AOutTgl:  r_dout <= r_dout ^ w_wd;
          AOe:      r_oe   <= w_wd;
          AEnRise:  r_rise <= w_wd;
          AEnFall:  r_fall <= w_wd;
          AEnHigh:  r_high <= w_wd;
          AEnLow:   r_low  <= w_wd;
          AFiltEn:  r_fen  <= w_wd;
          default: ;
        endcase
      end
    end
  end

  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign bus.err_o    = r_err;
  assign gpio_o       = r_dout;
  assign gpio_oe_o    = r_oe;
  assign irq_o        = r_state & r_en;
endmodule

// File: tb/tb_gpio_filt_irq.sv
// Directed bench for gpio_filt_irq (Width=8, FilterCycles=16) with a response scoreboard.
module tb_gpio_filt_irq;
  localparam int W  = 8;
  localparam int FC = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gpio_i = '0;
  logic [W-1:0] gpio_o, gpio_oe_o, irq_o;

  gpio_filt_irq_if bus();

  gpio_filt_irq #(.Width(W), .FilterCycles(FC)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rd; logic err; } exp_t;
  exp_t sb[$];
  int n_pass = 0, n_fail = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // one request cycle; the response is checked #1 after the following edge
  task automatic acc(input string tag, input logic we, input logic [5:0] a,
                     input logic [31:0] d, input logic [31:0] erd, input logic eerr);
    exp_t e;
    sb.push_back('{rd: erd, err: eerr});
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.wdata_i = d;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.we_i = 1'b0;
    e = sb.pop_front();
    chk({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'd1);
    chk({tag, ".rdata"},  bus.rdata_o, e.rd);
    chk({tag, ".err"},    32'(bus.err_o), 32'(e.err));
  endtask

  task automatic wr(input string tag, input logic [5:0] a, input logic [31:0] d);
    acc(tag, 1'b1, a, d, 32'h0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    acc(tag, 1'b0, a, 32'h0, exp, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle.rvalid", 32'(bus.rvalid_o), 32'd0);
    end
  endtask

  task automatic rdn(input string tag, input int n, input logic [31:0] exp);
    for (int i = 0; i < n; i++) rd(tag, 6'h0C, exp);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".gpio_o"}, 32'(gpio_o), 32'h0);
    chk({tag, ".oe"},     32'(gpio_oe_o), 32'h0);
    chk({tag, ".irq"},    32'(irq_o), 32'h0);
    chk({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'h0);
    chk({tag, ".rdata"},  bus.rdata_o, 32'h0);
    chk({tag, ".err"},    32'(bus.err_o), 32'h0);
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst = 1'b0;
    idle(1);

    // output path
    wr("dout", 6'h10, 32'h0000_00F0);
    wr("set",  6'h14, 32'h0000_0001);
    wr("clr",  6'h18, 32'h0000_0010);
    wr("tgl",  6'h1C, 32'h0000_0003);
    chk("gpio_o", 32'(gpio_o), 32'h0000_00E2);
    rd("dout_rb", 6'h10, 32'h0000_00E2);
    rd("outset_wo", 6'h14, 32'h0);

    // filtered input with glitches on pin 0
    wr("fen1", 6'h34, 32'h1);
    gpio_i[0] = 1'b1; rdn("glitch_a", 5, 32'h0);
    gpio_i[0] = 1'b0; rdn("glitch_b", 3, 32'h0);
    gpio_i[0] = 1'b1; rdn("glitch_c", 10, 32'h0);
    gpio_i[0] = 1'b0; rdn("glitch_d", 2, 32'h0);
    gpio_i[0] = 1'b1; rdn("filt_wait", 2 + FC, 32'h0);
    rd("filt_accept", 6'h0C, 32'h1);

    // rise interrupt on pin 3, filter off
    wr("fen0", 6'h34, 32'h0);
    wr("en_rise", 6'h24, 32'h8);
    wr("intr_en", 6'h04, 32'h8);
    gpio_i[3] = 1'b1; idle(6);
    rd("rise_state", 6'h00, 32'h8);
    chk("rise_irq", 32'(irq_o), 32'h8);
    wr("rise_w1c", 6'h00, 32'h8);
    rd("rise_cleared", 6'h00, 32'h0);
    chk("rise_irq_clr", 32'(irq_o), 32'h0);
    gpio_i[3] = 1'b0; idle(6);
    gpio_i[3] = 1'b1; idle(3);
    wr("rise_w1c_coinc", 6'h00, 32'h8);
    rd("rise_set_wins", 6'h00, 32'h8);
    chk("rise_irq_coinc", 32'(irq_o), 32'h8);
    wr("rise_w1c2", 6'h00, 32'h8);
    rd("rise_cleared2", 6'h00, 32'h0);

    // level-low interrupt on pin 5
    wr("en_low", 6'h30, 32'h20);
    idle(2);
    rd("low_state", 6'h00, 32'h20);
    chk("low_irq_masked", 32'(irq_o), 32'h0);
    wr("low_w1c", 6'h00, 32'h20);
    rd("low_persists", 6'h00, 32'h20);
    gpio_i[5] = 1'b1; idle(5);
    wr("low_w1c2", 6'h00, 32'h20);
    rd("low_cleared", 6'h00, 32'h0);

    // bus edge cases and width masking
    wr("test_all", 6'h08, 32'hFFFF_FFFF);
    rd("test_state", 6'h00, 32'h0000_00FF);
    chk("test_irq", 32'(irq_o), 32'h8);
    wr("test_w1c", 6'h00, 32'hFFFF_FFFF);
    rd("test_cleared", 6'h00, 32'h0);
    rd("test_wo", 6'h08, 32'h0);
    acc("unmap_rd", 1'b0, 6'h38, 32'h0, 32'h0, 1'b1);
    acc("unmap_wr", 1'b1, 6'h3C, 32'hFFFF_FFFF, 32'h0, 1'b1);
    rd("dout_kept", 6'h10, 32'h0000_00E2);
    rd("en_rise_rb", 6'h24, 32'h8);
    wr("oe_wide", 6'h20, 32'h0000_01FF);
    rd("oe_rb", 6'h20, 32'h0000_00FF);
    chk("gpio_oe", 32'(gpio_oe_o), 32'h0000_00FF);

    // reset mid filter count and mid access
    wr("fen_pin0", 6'h34, 32'h1);
    gpio_i[0] = 1'b0; idle(6);
    wr("test_b3", 6'h08, 32'h8);
    chk("pre_rst_irq", 32'(irq_o), 32'h8);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 6'h0C;
    #2 rst = 1'b1;
    #1 chk_outs_zero("rst_mid");
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    gpio_i[0] = 1'b1;
    chk("rst_abort_rvalid", 32'(bus.rvalid_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdn("post_rst_din", 3, 32'h0);
    rd("post_rst_din_acc", 6'h0C, 32'(gpio_i));
    rd("post_rst_dout", 6'h10, 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/gpio_filt_irq.md
GPIO_FILT_IRQ -- requirements
Module: gpio_filt_irq

Interface
REQ-001 SHALL have parameter Width, default 32, meaning pin count; legal range 1..32.
REQ-002 SHALL have parameter FilterCycles, default 16, meaning consecutive stable cycles needed to accept a filtered input change; legal range 2..65535.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset; asynchronous assert, active-high.
REQ-005 SHALL have port req_i, input, 1, meaning a register access is presented this cycle.
REQ-006 SHALL have port we_i, input, 1, meaning write (1) or read (0).
REQ-007 SHALL have port addr_i, input, 6, meaning byte address; addr_i[1:0] ignored.
REQ-008 SHALL have port wdata_i, input, 32, meaning write data.
REQ-009 SHALL have port rvalid_o, output, 1, meaning response valid.
REQ-010 SHALL have port rdata_o, output, 32, meaning read data.
REQ-011 SHALL have port err_o, output, 1, meaning the access hit an unmapped address.
REQ-012 SHALL have port gpio_i, input, Width, meaning asynchronous pin inputs.
REQ-013 SHALL have port gpio_o, output, Width, meaning output data.
REQ-014 SHALL have port gpio_oe_o, output, Width, meaning output enables.
REQ-015 SHALL have port irq_o, output, Width, meaning per-pin interrupt, equal to INTR_STATE & INTR_ENABLE.

Function
REQ-016 Register map SHALL be as follows.
- 0x00 INTR_STATE: RW1C.
- 0x04 INTR_ENABLE: RW.
- 0x08 INTR_TEST: WO; writing 1 sets the STATE bit.
- 0x0C DATA_IN: RO.
- 0x10 DATA_OUT: RW.
- 0x14 OUT_SET: WO; sets DATA_OUT bits.
- 0x18 OUT_CLR: WO; clears DATA_OUT bits.
- 0x1C OUT_TGL: WO; XORs DATA_OUT bits.
- 0x20 OE: RW.
- 0x24 EN_RISE, 0x28 EN_FALL, 0x2C EN_HIGH, 0x30 EN_LOW, 0x34 FILTER_EN: RW.
REQ-017 Write timing: a write SHALL take effect on the edge at which req_i&we_i is sampled.
REQ-018 Response timing: rvalid_o SHALL pulse exactly one cycle after every accepted req_i, read or write.
REQ-019 Read data: rdata_o SHALL hold the register value sampled with req_i; WO registers read 0; rdata_o = 0 when not a valid read response.
REQ-020 Unmapped addresses (0x38..0x3C): no state change; err_o=1 alongside rvalid_o; rdata_o=0.
REQ-021 Width masking: bits [31:Width] of every register SHALL read 0; writes to them are ignored.
REQ-022 Synchroniser: each gpio_i bit SHALL pass through a 2-flop synchroniser.
REQ-023 Filter enabled (FILTER_EN[i]=1): a per-pin counter SHALL restart on every change of the synchronised input.
- The filtered value updates once the input has been stable FilterCycles consecutive cycles.
- Counter saturates; no wrap.
REQ-024 Filter disabled: the filtered value SHALL equal the synchronised input, with a 1-cycle register.
REQ-025 FILTER_EN toggling SHALL reset that pin's counter; the filtered value SHALL never glitch to an unstable sample.
REQ-026 DATA_IN SHALL return the filtered value.
REQ-027 Event detection: the filtered value delayed by one cycle is the previous value (prev). Per-pin events:
- rise = ~prev & cur & EN_RISE
- fall = prev & ~cur & EN_FALL
- high = cur & EN_HIGH
- low = ~cur & EN_LOW
REQ-028 INTR_STATE[i] SHALL set on the edge following any event or INTR_TEST write bit.
- Set dominates a simultaneous W1C of the same bit.
- Level events re-set the bit each cycle while the level persists.
REQ-029 irq_o SHALL be combinational from the INTR_STATE and INTR_ENABLE flops; no extra latency.
REQ-030 gpio_o and gpio_oe_o SHALL be driven directly from the DATA_OUT and OE flops.

Reset
REQ-031 While rst_i=1, the following SHALL all be 0: every register, synchroniser, filter counter, prev, rvalid_o, err_o, rdata_o, gpio_o, gpio_oe_o and irq_o.
REQ-032 After reset release, the filtered value SHALL start from 0.
- A pin held high at release SHALL produce a rise event once accepted, if enabled.
REQ-033 Reset asserted mid-access SHALL abort the access; no rvalid_o pulse SHALL follow.

Verification
REQ-034 Output path: write DATA_OUT=0x0000_00F0, OUT_SET=0x1, OUT_CLR=0x10, OUT_TGL=0x3 -> gpio_o=0x0000_00E2; each write gets rvalid_o 1 cycle later with err_o=0.
REQ-035 Filtered input: FILTER_EN[0]=1; gpio_i[0] 0->1 held, with glitches shorter than 16 cycles beforehand -> DATA_IN[0] rises exactly 2+16 cycles after the final transition, and never before.
REQ-036 Rise interrupt: EN_RISE[3]=1, INTR_ENABLE[3]=1, filter off, gpio_i[3] 0->1 -> INTR_STATE[3] and irq_o[3] go high; W1C 0x8 clears them; a rise coincident with the W1C leaves the bit set.
REQ-037 Level interrupt: EN_LOW[5]=1 with the pin low -> W1C does not clear the bit while low; after the pin goes high, W1C clears it.
REQ-038 Bus edge cases: INTR_TEST=0xFFFF_FFFF with Width=8 -> INTR_STATE reads 0x0000_00FF; read of 0x38 -> err_o=1, rdata_o=0.
REQ-039 Reset mid-operation: assert rst_i mid-filter-count with outputs driven -> all outputs 0 immediately; after release the filter restarts from 0.
